layer_seq: RTL and testbench

//  Layer/image scheduler that sits above the NPU control fsm. It accepts one host command,

---
 rtl/layer_seq.sv | 197 +++++++++++++++++++
 tb/tb_layer_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq.sv
// layer_seq: layer/image scheduler that sits above the NPU control fsm.
//
// One host command is accepted in IDLE. For every image the scheduler runs
// layer C1 and, when enabled, layer C2. Each layer is a CFG settle window
// followed by a one-cycle fsm_start and a RUN phase that waits for fsm_done.
// The ping-pong activation buffer select flips after every layer, and the
// completed-image count is kept in img_cnt. A RUN watchdog, an abort input
// and done/error interrupts are provided.
//
// Command handshake: a command transfers on a rising clock edge where
// cmd_valid and cmd_ready are both 1. cmd_ready is 1 only in IDLE. cmd_valid
// outside IDLE is ignored: nothing is queued and the host must present the
// command again once cmd_ready returns.
//
// Ports:
//   ck, rst           clock, asynchronous active-high reset
//   cmd_valid/ready   host command handshake
//   cmd_nimg          number of images in the job (0 completes immediately)
//   cmd_l2_en         run C2 after C1 for each image
//   abort             cancel the current job
//   fsm_start         one-cycle start pulse to the NPU fsm
//   fsm_done          NPU fsm done (level or pulse; only the rising edge counts)
//   c1_c2_n           layer select to ctrl_param (0 = C1, 1 = C2)
//   buf_sel           ping-pong buffer that holds the current layer input
//   npu_clr           one-cycle clear pulse for the NPU datapath/fsm
//   busy              job in progress (not IDLE, not ERR)
//   img_cnt           images completed in the current/last job
//   irq_done          one-cycle pulse on job completion
//   irq_err           watchdog error, held until abort
//   state_dbg         current scheduler state encoding
module layer_seq #(
  parameter int IMG_W   = 8,
  parameter int CFG_CYC = 2,
  parameter int TMO_W   = 20
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IMG_W-1:0] cmd_nimg,
  input  logic             cmd_l2_en,
  input  logic             abort,
  output logic             fsm_start,
  input  logic             fsm_done,
  output logic             c1_c2_n,
  output logic             buf_sel,
  output logic             npu_clr,
  output logic             busy,
  output logic [IMG_W-1:0] img_cnt,
  output logic             irq_done,
  output logic             irq_err,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_SWAP  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam int CW = (CFG_CYC > 1) ? $clog2(CFG_CYC) : 1;
  localparam logic [CW-1:0]    CFG_LAST = CW'(CFG_CYC - 1);
  localparam logic [TMO_W-1:0] WDOG_MAX = '1;

  state_t           state, state_d;
  logic [CW-1:0]    cfg_cnt, cfg_cnt_d;
  logic [TMO_W-1:0] wdog, wdog_d;
  logic [IMG_W-1:0] nimg_q, nimg_d;
  logic [IMG_W-1:0] img_d, img_inc;
  logic             l2_q, l2_d;
  logic             sel_d, buf_d, clr_d;
  logic             done_q, done_rise;

  // A level-held fsm_done is seen only once, on its rising edge.
  assign done_rise = fsm_done & ~done_q;
  assign img_inc   = img_cnt + 1'b1;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE) && (state != S_ERR);
  assign irq_err   = (state == S_ERR);
  assign state_dbg = state;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cfg_cnt <= '0;
      wdog    <= '0;
      nimg_q  <= '0;
      l2_q    <= 1'b0;
      c1_c2_n <= 1'b0;
      buf_sel <= 1'b0;
      img_cnt <= '0;
      npu_clr <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cfg_cnt <= cfg_cnt_d;
      wdog    <= wdog_d;
      nimg_q  <= nimg_d;
      l2_q    <= l2_d;
      c1_c2_n <= sel_d;
      buf_sel <= buf_d;
      img_cnt <= img_d;
      npu_clr <= clr_d;
      done_q  <= fsm_done;
    end
  end

  always_comb begin
    state_d   = state;
    cfg_cnt_d = cfg_cnt;
    wdog_d    = wdog;
    nimg_d    = nimg_q;
    l2_d      = l2_q;
    sel_d     = c1_c2_n;
    buf_d     = buf_sel;
    img_d     = img_cnt;
    clr_d     = 1'b0;
    fsm_start = 1'b0;
    irq_done  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          nimg_d    = cmd_nimg;
          l2_d      = cmd_l2_en;
          img_d     = '0;
          sel_d     = 1'b0;
          cfg_cnt_d = '0;
          state_d   = (cmd_nimg == '0) ? S_DONE : S_CFG;
        end
      end
      S_CFG: begin
        // c1_c2_n is stable for CFG_CYC cycles so ctrl_param/dp settle.
        if (cfg_cnt == CFG_LAST) state_d = S_START;
        else                     cfg_cnt_d = cfg_cnt + 1'b1;
      end
      S_START: begin
        fsm_start = 1'b1;
        wdog_d    = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        wdog_d = wdog + 1'b1;
        if (done_rise) begin
          state_d = S_SWAP;
        end else if (wdog == WDOG_MAX - 1'b1) begin
          // wdog reaches its all-ones value as the error is raised.
          state_d = S_ERR;
          clr_d   = 1'b1;
        end
      end
      S_SWAP: begin
        buf_d     = ~buf_sel;
        cfg_cnt_d = '0;
        if (!c1_c2_n && l2_q) begin
          sel_d   = 1'b1;
          state_d = S_CFG;
        end else begin
          img_d = img_inc;
          if (img_inc == nimg_q) begin
            state_d = S_DONE;
          end else begin
            sel_d   = 1'b0;
            state_d = S_CFG;
          end
        end
      end
      S_DONE: begin
        irq_done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition of an active or errored job; all job
    // registers hold, and the NPU is cleared only if it may be running.
    if (abort && (state inside {S_CFG, S_START, S_RUN, S_SWAP, S_ERR})) begin
      state_d   = S_IDLE;
      fsm_start = 1'b0;
      cfg_cnt_d = cfg_cnt;
      wdog_d    = wdog;
      sel_d     = c1_c2_n;
      buf_d     = buf_sel;
      img_d     = img_cnt;
      clr_d     = (state == S_START) || (state == S_RUN);
    end
  end

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq with a small NPU stand-in driven from tasks.
module tb_layer_seq;
  localparam int IMG_W   = 8;
  localparam int CFG_CYC = 2;
  localparam int TMO_W   = 6;

  logic             ck = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IMG_W-1:0] cmd_nimg;
  logic             cmd_l2_en;
  logic             abort;
  logic             fsm_start;
  logic             fsm_done;
  logic             c1_c2_n;
  logic             buf_sel;
  logic             npu_clr;
  logic             busy;
  logic [IMG_W-1:0] img_cnt;
  logic             irq_done;
  logic             irq_err;
  logic [2:0]       state_dbg;

  layer_seq #(.IMG_W(IMG_W), .CFG_CYC(CFG_CYC), .TMO_W(TMO_W)) dut (
    .ck(ck), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_nimg(cmd_nimg), .cmd_l2_en(cmd_l2_en), .abort(abort),
    .fsm_start(fsm_start), .fsm_done(fsm_done), .c1_c2_n(c1_c2_n),
    .buf_sel(buf_sel), .npu_clr(npu_clr), .busy(busy), .img_cnt(img_cnt),
    .irq_done(irq_done), .irq_err(irq_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 ck = ~ck;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end, required end of test");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];   // expected c1_c2_n at each fsm_start
  int start_cnt = 0;
  int done_cnt  = 0;
  int clr_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge ck) begin
    if (!rst) begin
      if (fsm_start) begin
        start_cnt++;
        if (exp_q.size() == 0) check("start_unexpected", {31'b0, fsm_start}, 32'd0);
        else                   check("start_layer_sel", {31'b0, c1_c2_n}, exp_q.pop_front());
      end
      if (irq_done) done_cnt++;
      if (npu_clr)  clr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  // Every step lands just after the falling edge, after the monitor has run.
  task automatic tick();
    @(negedge ck);
    #1;
  endtask

  task automatic send_cmd(input int n, input bit l2);
    cmd_nimg  = IMG_W'(n);
    cmd_l2_en = l2;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (fsm_start) begin
        ok = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    if (!ok) check("start_timeout", {31'b0, fsm_start}, 32'd1);
  endtask

  task automatic wait_irq();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (irq_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("irq_done_timeout", {31'b0, irq_done}, 32'd1);
  endtask

  task automatic pulse_done(input int delay, input int hold);
    repeat (delay) tick();
    fsm_done = 1'b1;
    repeat (hold) tick();
    fsm_done = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    check({tag, "_busy"},      {31'b0, busy},      32'd0);
    check({tag, "_fsm_start"}, {31'b0, fsm_start}, 32'd0);
    check({tag, "_c1_c2_n"},   {31'b0, c1_c2_n},   32'd0);
    check({tag, "_buf_sel"},   {31'b0, buf_sel},   32'd0);
    check({tag, "_npu_clr"},   {31'b0, npu_clr},   32'd0);
    check({tag, "_img_cnt"},   {24'b0, img_cnt},   32'd0);
    check({tag, "_irq_done"},  {31'b0, irq_done},  32'd0);
    check({tag, "_irq_err"},   {31'b0, irq_err},   32'd0);
  endtask

  // ---------------- tests ----------------
  initial begin
    int cyc;
    int s0, d0, c0;
    logic exp_buf;

    rst = 1'b1; cmd_valid = 1'b0; cmd_nimg = '0; cmd_l2_en = 1'b0;
    abort = 1'b0; fsm_done = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // T1: one image, C1 only, done 50 cycles after start.
    exp_q.push_back(32'd0);
    send_cmd(1, 1'b0);
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    wait_start(cyc);
    check("t1_first_start_latency", cyc, CFG_CYC);
    pulse_done(50, 1);
    wait_irq();
    check("t1_img_cnt", {24'b0, img_cnt}, 32'd1);
    check("t1_buf_sel", {31'b0, buf_sel}, 32'd1);
    tick();
    check("t1_irq_done_one_cycle", {31'b0, irq_done}, 32'd0);
    check("t1_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    check("t1_start_cnt", start_cnt, 32'd1);

    // T2: two images with C2, four layers alternating C1/C2.
    exp_buf = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k % 2));
    send_cmd(2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_start(cyc);
      if (k > 0) check("t2_done_to_start_latency", cyc + 1, CFG_CYC + 2);
      check("t2_buf_sel_at_start", {31'b0, buf_sel}, {31'b0, exp_buf});
      check("t2_img_cnt_at_start", {24'b0, img_cnt}, 32'(k / 2));
      pulse_done(20, 1);
      exp_buf = ~exp_buf;
    end
    wait_irq();
    check("t2_img_cnt", {24'b0, img_cnt}, 32'd2);
    check("t2_buf_sel_final", {31'b0, buf_sel}, {31'b0, exp_buf});
    check("t2_done_cnt", done_cnt, 32'd2);
    tick();

    // T3: zero images completes without any start.
    s0 = start_cnt;
    send_cmd(0, 1'b0);
    check("t3_irq_done", {31'b0, irq_done}, 32'd1);
    check("t3_img_cnt", {24'b0, img_cnt}, 32'd0);
    tick();
    check("t3_irq_done_one_cycle", {31'b0, irq_done}, 32'd0);
    check("t3_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("t3_no_start", start_cnt, s0);

    // T4: held done counted once; command while busy ignored.
    s0 = start_cnt;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    send_cmd(2, 1'b0);
    wait_start(cyc);
    tick();
    check("t4_cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
    send_cmd(5, 1'b1);
    pulse_done(5, 10);
    check("t4_img_cnt_after_held_done", {24'b0, img_cnt}, 32'd1);
    check("t4_still_busy", {31'b0, busy}, 32'd1);
    check("t4_second_start", start_cnt, s0 + 2);
    pulse_done(10, 1);
    wait_irq();
    check("t4_img_cnt_final", {24'b0, img_cnt}, 32'd2);
    tick();
    check("t4_start_total", start_cnt, s0 + 2);

    // T5: watchdog error after 63 RUN cycles, then abort.
    d0 = done_cnt;
    c0 = clr_cnt;
    exp_q.push_back(32'd0);
    send_cmd(1, 1'b0);
    wait_start(cyc);
    tick();                     // first RUN cycle
    repeat (62) tick();         // 63rd RUN cycle
    check("t5_run_before_tmo", {31'b0, busy}, 32'd1);
    check("t5_no_err_yet", {31'b0, irq_err}, 32'd0);
    tick();
    check("t5_irq_err", {31'b0, irq_err}, 32'd1);
    check("t5_npu_clr_entry", {31'b0, npu_clr}, 32'd1);
    check("t5_not_busy", {31'b0, busy}, 32'd0);
    repeat (5) tick();
    check("t5_irq_err_sticky", {31'b0, irq_err}, 32'd1);
    check("t5_clr_once", clr_cnt, c0 + 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle_after_abort", {31'b0, cmd_ready}, 32'd1);
    check("t5_irq_err_cleared", {31'b0, irq_err}, 32'd0);
    check("t5_no_clr_from_err", {31'b0, npu_clr}, 32'd0);
    check("t5_no_irq_done", done_cnt, d0);

    // T6: abort during RUN of image 2.
    d0 = done_cnt;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    send_cmd(3, 1'b0);
    wait_start(cyc);
    pulse_done(10, 1);
    wait_start(cyc);
    repeat (2) tick();
    check("t6_img_cnt_before_abort", {24'b0, img_cnt}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_idle", {31'b0, cmd_ready}, 32'd1);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_npu_clr", {31'b0, npu_clr}, 32'd1);
    tick();
    check("t6_npu_clr_one_cycle", {31'b0, npu_clr}, 32'd0);
    check("t6_img_cnt_held", {24'b0, img_cnt}, 32'd1);
    repeat (5) tick();
    check("t6_no_irq_done", done_cnt, d0);

    // Asynchronous reset in the middle of CFG.
    send_cmd(1, 1'b0);
    check("t6_in_cfg", {29'b0, state_dbg}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("midcfg_rst");
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("rst_no_start", {31'b0, cmd_ready}, 32'd1);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
